// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver with start qualification, stop check and error pulses
module uart_receiver #(
  parameter int SIZE_DATA = 8,
  parameter int OVER_SAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stick,
  input  logic                 i_rx_serial,
  input  logic                 i_fifo_full,
  output logic [SIZE_DATA-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_rx_busy
);
  localparam int CW = $clog2(OVER_SAMPLE);
  localparam int IW = $clog2(SIZE_DATA) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, nxt;
  logic [1:0] sync;
  logic rx_s, samp, valid_d, ferr_d, ovr_d;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [SIZE_DATA-1:0] sh;
  assign rx_s = sync[1];
  assign samp = i_stick && cnt == ((state == START) ? CW'(OVER_SAMPLE / 2 - 1) : CW'(OVER_SAMPLE - 1));
  // Two-flop synchronizer, idle-high reset so no false start after reset
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) sync <= 2'b11;
    else sync <= {sync[0], i_rx_serial};
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  // Next state: IDLE and BRK react to the line directly, others only on the sample tick
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = rx_s ? IDLE : START;
      START:   nxt = !samp ? START : (rx_s ? IDLE : DATA);
      DATA:    nxt = (samp && idx == IW'(SIZE_DATA - 1)) ? STOP : DATA;
      STOP:    nxt = !samp ? STOP : (rx_s ? IDLE : BRK);
      BRK:     nxt = rx_s ? IDLE : BRK;
      default: nxt = IDLE;
    endcase
  end
  // Outputs: stop-sample verdicts and busy flag
  always_comb begin
    valid_d = state == STOP && samp && rx_s && !i_fifo_full;
    ovr_d = state == STOP && samp && rx_s && i_fifo_full;
    ferr_d = state == STOP && samp && !rx_s;
    o_rx_busy = state != IDLE;
  end
  // Sample counter, bit index, shift register and registered result pulses
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      o_rx_data <= '0;
      o_rx_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      cnt <= (state == IDLE || state == BRK || samp) ? '0 : i_stick ? cnt + CW'(1) : cnt;
      idx <= (state == IDLE) ? '0 : (state == DATA && samp) ? idx + IW'(1) : idx;
      sh <= (state == DATA && samp) ? {rx_s, sh[SIZE_DATA-1:1]} : sh;
      o_rx_data <= valid_d ? sh : o_rx_data;
      o_rx_valid <= valid_d;
      o_frame_err <= ferr_d;
      o_overrun <= ovr_d;
    end
endmodule
